ldvio_commit_ctrl: RTL
======================

// Module: ldvio_commit_ctrl
// PURPOSE
//  Commit-side consumer of the per-active-list-entry load-violation bits.
//  - Each cycle, reads the violation bit for the COMMIT_WIDTH oldest active-list entries.
//  - Reports how many in-order completed entries retire.
//  - On a violating load, stops retirement, raises a flush to re-fetch from the load's PC,
//    and holds commit until recovery has drained.
//  - Sits between the active-list head and the fetch/recovery logic.
// PARAMETERS
//  COMMIT_WIDTH  4   entries examined per cycle (1..8)
//  AL_DEPTH      128 active-list entries (power of two)
//  AL_INDEX      7   log2(AL_DEPTH)
//  PC_WIDTH      32  instruction address width
//  DRAIN_CYCLES  3   post-flush cycles with commit held; 0 = no drain
// PORTS
//  clk             in  1                      clock
//  reset           in  1                      sync active-high reset
//  headPtr_i       in  AL_INDEX               active-list head index
//  completed_i     in  COMMIT_WIDTH           bit i: entry head+i has completed
//  isLoad_i        in  COMMIT_WIDTH           bit i: entry head+i is a load
//  pc_i            in  COMMIT_WIDTH*PC_WIDTH  PC of entry head+i
//  ldvioAddr_o     out COMMIT_WIDTH*AL_INDEX  violation-bit read addresses
//  ldvioData_i     in  COMMIT_WIDTH           violation bits, same cycle (async read)
//  commitCount_o   out $clog2(COMMIT_WIDTH+1) entries retiring this cycle
//  flushReq_o      out 1                      recovery request, held until acked
//  flushPc_o       out PC_WIDTH               re-fetch PC; valid while flushReq_o=1
//  flushAck_i      in  1                      recovery accepted
//  recoveryBusy_o  out 1                      state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; drain counter=0.
//  Addressing:
//  - ldvioAddr_o[i] = (headPtr_i+i) mod AL_DEPTH; wraps past AL_DEPTH-1 to 0.
//  - Combinational from headPtr_i in every state.
//  Scan (IDLE only, combinational):
//  - viol[i] = ldvioData_i[i] & isLoad_i[i]; a violation bit on a non-load is ignored.
//  - commitCount_o = number of leading i with completed_i[i]=1 and viol[i]=0;
//    the scan stops at the first incomplete or violating entry.
//  - Trigger: the entry at index k=commitCount_o satisfies k<COMMIT_WIDTH,
//    completed_i[k]=1 and viol[k]=1.
//  - When triggered, entries 0..k-1 still commit this cycle; entry k does not commit.
//  Violation FSM:
//  - IDLE: on trigger, register flushPc_o<=pc_i[k] and go to FLUSH.
//  - FLUSH: flushReq_o=1, commitCount_o=0.
//    - On flushAck_i: load counter=DRAIN_CYCLES, then go to DRAIN
//      (or straight to IDLE if DRAIN_CYCLES=0).
//    - An ack in the first FLUSH cycle is honoured.
//  - DRAIN: commitCount_o=0; counter decrements; move to IDLE on the edge where counter==1.
//  Latency: trigger in cycle t -> flushReq_o=1 in t+1.
//  - Minimum turnaround: ack at t+1 -> IDLE scan resumes at t+2+DRAIN_CYCLES.
//  Boundary cases:
//  - flushAck_i outside FLUSH is ignored.
//  - completed_i, ldvioData_i and pc_i are don't-care outside IDLE.
//  - Only the oldest violation is taken. Younger ones are squashed by the flush.
//  - Reset in any state -> IDLE next edge, flushReq_o=0, pending flush discarded.
// CONFIGURATION
//  LDVIO_STATS_EN defined:
//  - Adds output violationCnt_o [31:0], reset 0.
//  - +1 on each IDLE->FLUSH transition; saturates at 32'hFFFF_FFFF.
//  LDVIO_STATS_EN undefined: no port and no counter logic.
// STRUCTURE
//  Shared package (ldvio_pkg):
//  - typedef enum logic [1:0] {LDVIO_IDLE, LDVIO_FLUSH, LDVIO_DRAIN} ldvio_state_t.
//  - Default constants for COMMIT_WIDTH and DRAIN_CYCLES.
//  Sub-module ldvio_commit_scan: purely combinational leading-count and trigger/index
//  priority scan. FSM, PC register and counters stay in the top.
// TESTING
//  - Wrap: head=126, all completed, no viol -> ldvioAddr_o={126,127,0,1}, commitCount_o=4.
//  - Viol at slot 2 (load), slots 0-3 completed, pc[2]=0x400 -> commitCount_o=2;
//    next cycle flushReq_o=1, flushPc_o=0x400.
//  - Ack on first FLUSH cycle, DRAIN_CYCLES=3 -> 3 cycles commitCount_o=0 in DRAIN,
//    then IDLE. Delayed ack (5 cycles) -> flushReq_o held for 5 cycles.
//  - Bit set on non-load slot 0 -> ignored, commitCount_o=4. Slot 1 incomplete with viol
//    -> commitCount_o=1, no flush.
//  - Reset asserted in FLUSH -> next cycle flushReq_o=0, IDLE, violationCnt_o=0 (stats).
//  - LDVIO_STATS_EN: 3 violations -> violationCnt_o=3. Preloaded at max -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/ldvio_pkg.sv
// Shared types and defaults for the load-violation commit controller.
// Holds the recovery FSM state encoding and the default commit/drain sizing.
package ldvio_pkg;

   typedef enum logic [1:0] {LDVIO_IDLE, LDVIO_FLUSH, LDVIO_DRAIN} ldvio_state_t;

   localparam int LDVIO_COMMIT_WIDTH = 4;
   localparam int LDVIO_DRAIN_CYCLES = 3;

   // Bit width able to index v items, never narrower than one bit.
   function automatic int ldvio_clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/ldvio_commit_scan.sv
// In-order retire scan over the oldest active-list entries; purely combinational.
// Counts leading completed non-violating entries and flags the first completed violating load.
module ldvio_commit_scan
   import ldvio_pkg::*;
#(
   parameter int COMMIT_WIDTH = LDVIO_COMMIT_WIDTH,
   parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1),
   parameter int IDX_W        = ldvio_clog2_min1(COMMIT_WIDTH)
) (
   input  logic [COMMIT_WIDTH-1:0] completed_i,
   input  logic [COMMIT_WIDTH-1:0] isLoad_i,
   input  logic [COMMIT_WIDTH-1:0] ldvioData_i,
   output logic [CNT_W-1:0]        count_o,
   output logic                    trig_o,
   output logic [IDX_W-1:0]        idx_o
);

   logic [COMMIT_WIDTH-1:0] viol;
   logic                    stop;

   // A violation bit on a non-load entry is meaningless and must not stall retirement.
   assign viol = ldvioData_i & isLoad_i;

   always_comb begin
      count_o = '0;
      trig_o  = 1'b0;
      idx_o   = '0;
      stop    = 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (!stop) begin
            if (completed_i[i] && !viol[i]) begin
               count_o = count_o + CNT_W'(1);
            end else begin
               stop   = 1'b1;
               trig_o = completed_i[i];
               idx_o  = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/ldvio_commit_ctrl.sv
// Commit-side load-violation controller: retires in-order entries, flushes on the oldest violating load.
// Flush request one cycle after trigger, held until flushAck_i; commit then held DRAIN_CYCLES. Optional LDVIO_STATS_EN counter.
module ldvio_commit_ctrl
   import ldvio_pkg::*;
#(
   parameter int COMMIT_WIDTH = LDVIO_COMMIT_WIDTH,
   parameter int AL_DEPTH     = 128,
   parameter int AL_INDEX     = 7,
   parameter int PC_WIDTH     = 32,
   parameter int DRAIN_CYCLES = LDVIO_DRAIN_CYCLES
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [AL_INDEX-1:0]               headPtr_i,
   input  logic [COMMIT_WIDTH-1:0]           completed_i,
   input  logic [COMMIT_WIDTH-1:0]           isLoad_i,
   input  logic [COMMIT_WIDTH*PC_WIDTH-1:0]  pc_i,
   output logic [COMMIT_WIDTH*AL_INDEX-1:0]  ldvioAddr_o,
   input  logic [COMMIT_WIDTH-1:0]           ldvioData_i,
   output logic [$clog2(COMMIT_WIDTH+1)-1:0] commitCount_o,
   output logic                              flushReq_o,
   output logic [PC_WIDTH-1:0]               flushPc_o,
   input  logic                              flushAck_i,
   output logic                              recoveryBusy_o
`ifdef LDVIO_STATS_EN
   ,output logic [31:0]                      violationCnt_o
`endif
);

   localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
   localparam int IDX_W = ldvio_clog2_min1(COMMIT_WIDTH);
   localparam int DRN_W = ldvio_clog2_min1(DRAIN_CYCLES + 1);

   ldvio_state_t        state_q, state_d;
   logic                flush_req_q, flush_req_d;
   logic                busy_q, busy_d;
   logic [PC_WIDTH-1:0] flush_pc_q, flush_pc_d;
   logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;

   logic [CNT_W-1:0]    scan_cnt;
   logic                scan_trig;
   logic [IDX_W-1:0]    scan_idx;

   always_comb begin
      ldvioAddr_o = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         ldvioAddr_o[i*AL_INDEX +: AL_INDEX] = AL_INDEX'((int'(headPtr_i) + i) % AL_DEPTH);
      end
   end

   ldvio_commit_scan #(
      .COMMIT_WIDTH (COMMIT_WIDTH),
      .CNT_W        (CNT_W),
      .IDX_W        (IDX_W)
   ) u_scan (
      .completed_i (completed_i),
      .isLoad_i    (isLoad_i),
      .ldvioData_i (ldvioData_i),
      .count_o     (scan_cnt),
      .trig_o      (scan_trig),
      .idx_o       (scan_idx)
   );

   // Retirement only happens while idle; the head inputs are stale during recovery.
   assign commitCount_o  = (state_q == LDVIO_IDLE) ? scan_cnt : '0;
   assign flushReq_o     = flush_req_q;
   assign flushPc_o      = flush_pc_q;
   assign recoveryBusy_o = busy_q;

   always_comb begin
      state_d     = state_q;
      flush_pc_d  = flush_pc_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         LDVIO_IDLE: begin
            if (scan_trig) begin
               state_d    = LDVIO_FLUSH;
               flush_pc_d = pc_i[int'(scan_idx)*PC_WIDTH +: PC_WIDTH];
            end
         end
         LDVIO_FLUSH: begin
            if (flushAck_i) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d = LDVIO_IDLE;
               end else begin
                  state_d     = LDVIO_DRAIN;
                  drain_cnt_d = DRN_W'(DRAIN_CYCLES);
               end
            end
         end
         LDVIO_DRAIN: begin
            drain_cnt_d = drain_cnt_q - DRN_W'(1);
            if (drain_cnt_q == DRN_W'(1)) begin
               state_d = LDVIO_IDLE;
            end
         end
         default: state_d = LDVIO_IDLE;
      endcase
      flush_req_d = (state_d == LDVIO_FLUSH);
      busy_d      = (state_d != LDVIO_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LDVIO_IDLE;
         flush_req_q <= 1'b0;
         busy_q      <= 1'b0;
         flush_pc_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_req_q <= flush_req_d;
         busy_q      <= busy_d;
         flush_pc_q  <= flush_pc_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

`ifdef LDVIO_STATS_EN
   logic [31:0] vcnt_q, vcnt_d;

   always_comb begin
      vcnt_d = vcnt_q;
      if (state_q == LDVIO_IDLE && scan_trig && vcnt_q != 32'hFFFF_FFFF) begin
         vcnt_d = vcnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vcnt_q <= '0;
      end else begin
         vcnt_q <= vcnt_d;
      end
   end

   assign violationCnt_o = vcnt_q;
`endif

endmodule
